// File: rtl/sm4_crypt_engine.sv
// SM4 block cipher engine: iterative core with a cached round-key file,
// ECB/CBC chaining, encrypt and decrypt.
//
// Handshake: a request transfers on a rising edge where v_i && ready_o.
// ready_o is high only in IDLE. A result is offered with v_o and is
// consumed on a rising edge where v_o && yumi_i. data_o holds steady
// while v_o is high. yumi_i is ignored while v_o is low.
//
// Timing: accept edge -> KEYEXP (iter_lp cycles, only if expanding) ->
// CRYPT (one load cycle + iter_lp round cycles) -> DONE.
// The load cycle applies the CBC pre-whitening before the first round.
// Data words: X0 is content[127:96].
module sm4_crypt_engine #(
  parameter int group_size_p       = 128,
  parameter int rounds_per_cycle_p = 1,
  parameter bit cbc_en_p           = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [group_size_p-1:0] content_i,
  input  logic [group_size_p-1:0] key_i,
  input  logic                    key_new_i,
  input  logic                    encode_or_decode_i,
  input  logic                    mode_i,
  input  logic [group_size_p-1:0] iv_i,
  input  logic                    iv_load_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [group_size_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [1:0]              state_o
);

  localparam int         rpc_lp  = rounds_per_cycle_p;
  localparam logic [4:0] step_lp = 5'(rounds_per_cycle_p);
  localparam logic [4:0] last_lp = 5'(32 - rounds_per_cycle_p);

  localparam logic [127:0] fk_lp = 128'ha3b1bac656aa3350677d9197b27022dc;

  localparam logic [2047:0] sbox_lp = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    CRYPT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Byte b sits at bit 2047-8*b, i.e. {~b, 3'b111} as an 11-bit index.
  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return sbox_lp[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] tau_f(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

  // Linear transform of the data rounds.
  function automatic logic [31:0] l_enc_f(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^
           {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  // Linear transform of the key schedule.
  function automatic logic [31:0] l_key_f(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // CK[i] byte j = (4i+j)*7 mod 256, byte 0 most significant.
  function automatic logic [31:0] ck_f(input logic [4:0] i);
    logic [7:0]  n;
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      n = {1'b0, i, 2'b00} + 8'(j);
      r[31-8*j -: 8] = n * 8'd7;
    end
    return r;
  endfunction

  state_e        state_q, state_n;
  logic [127:0]  content_q;
  logic [127:0]  k_q;
  logic [127:0]  x_q;
  logic [127:0]  chain_q;
  logic [127:0]  data_q;
  logic          enc_q;
  logic          cbc_q;
  logic          cached_q;
  logic          pre_q;
  logic [4:0]    rnd_q;
  logic [31:0]   rk_q [32];

  logic          accept;
  logic          expand;
  logic          last_round;
  logic [127:0]  kw [rpc_lp+1];
  logic [31:0]   kr [rpc_lp];
  logic [4:0]    kidx [rpc_lp];
  logic [127:0]  xw [rpc_lp+1];
  logic [31:0]   rk_sel;
  logic [127:0]  x_init;
  logic [127:0]  core_out;
  logic [127:0]  result;

  assign accept     = v_i && ready_o;
  assign expand     = key_new_i || !cached_q;
  assign last_round = (rnd_q == last_lp);

  // Unrolled key-schedule and cipher rounds for one clock; decode walks rk backwards.
  always_comb begin
    rk_sel = '0;
    kw[0]  = k_q;
    xw[0]  = x_q;
    for (int j = 0; j < rpc_lp; j++) begin
      kidx[j]  = rnd_q + 5'(j);
      kr[j]    = kw[j][127:96] ^
                 l_key_f(tau_f(kw[j][95:64] ^ kw[j][63:32] ^ kw[j][31:0] ^ ck_f(kidx[j])));
      kw[j+1]  = {kw[j][95:0], kr[j]};
      rk_sel   = enc_q ? rk_q[kidx[j]] : rk_q[~kidx[j]];
      xw[j+1]  = {xw[j][95:0],
                  xw[j][127:96] ^ l_enc_f(tau_f(xw[j][95:64] ^ xw[j][63:32] ^ xw[j][31:0] ^ rk_sel))};
    end
  end

  // CBC whitening on the way in and the reverse transform R on the way out.
  always_comb begin
    x_init   = (cbc_q && enc_q) ? (content_q ^ chain_q) : content_q;
    core_out = {xw[rpc_lp][31:0], xw[rpc_lp][63:32], xw[rpc_lp][95:64], xw[rpc_lp][127:96]};
    result   = (cbc_q && !enc_q) ? (core_out ^ chain_q) : core_out;
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (v_i) state_n = expand ? KEYEXP : CRYPT;
      KEYEXP:  if (last_round) state_n = CRYPT;
      CRYPT:   if (!pre_q && last_round) state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready_o = (state_q == IDLE);
    v_o     = (state_q == DONE);
    state_o = state_q;
  end

  assign data_o = data_q;

  // Request latch, key expansion, cipher rounds, chain and result registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      content_q <= '0;
      k_q       <= '0;
      x_q       <= '0;
      chain_q   <= '0;
      data_q    <= '0;
      enc_q     <= 1'b0;
      cbc_q     <= 1'b0;
      cached_q  <= 1'b0;
      pre_q     <= 1'b0;
      rnd_q     <= '0;
      for (int i = 0; i < 32; i++) rk_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            content_q <= content_i;
            enc_q     <= encode_or_decode_i;
            cbc_q     <= cbc_en_p && mode_i;
            rnd_q     <= '0;
            pre_q     <= 1'b1;
            if (expand) k_q <= key_i ^ fk_lp;
            if (cbc_en_p && mode_i && iv_load_i) chain_q <= iv_i;
          end
        end
        KEYEXP: begin
          for (int j = 0; j < rpc_lp; j++) rk_q[kidx[j]] <= kr[j];
          k_q   <= kw[rpc_lp];
          rnd_q <= rnd_q + step_lp;   // wraps to 0 after the last group
          if (last_round) cached_q <= 1'b1;
        end
        CRYPT: begin
          if (pre_q) begin
            x_q   <= x_init;
            pre_q <= 1'b0;
          end else begin
            x_q   <= xw[rpc_lp];
            rnd_q <= rnd_q + step_lp;
            if (last_round) begin
              data_q <= result;
              if (cbc_q) chain_q <= enc_q ? core_out : content_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_crypt_engine.sv
// Directed bench for sm4_crypt_engine: standard SM4 vector, cached-key
// reuse, rounds-per-cycle sweep, CBC chaining, backpressure, mid-run reset.
module tb_sm4_crypt_engine;

  localparam logic [127:0] p1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] k1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] c1 = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] content, key, iv;
  logic         key_new, enc, mode, iv_load, v_in, yumi;
  logic         ready, v_out;
  logic [127:0] data;
  logic [1:0]   state;

  logic         v_sw;
  logic [2:0]   yumi_sw;
  logic [2:0]   ready_s, v_s;
  logic [127:0] data_s [3];
  logic [1:0]   state_s [3];

  logic [127:0] p2;
  logic [127:0] exp_q [$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  sm4_crypt_engine #(.rounds_per_cycle_p(1)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .content_i(content), .key_i(key),
    .key_new_i(key_new), .encode_or_decode_i(enc), .mode_i(mode), .iv_i(iv),
    .iv_load_i(iv_load), .v_i(v_in), .ready_o(ready), .data_o(data),
    .v_o(v_out), .yumi_i(yumi), .state_o(state)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    sm4_crypt_engine #(.rounds_per_cycle_p(2 << g)) u_sw (
      .clk_i(clk), .reset_n_i(rst_n), .content_i(content), .key_i(key),
      .key_new_i(key_new), .encode_or_decode_i(enc), .mode_i(mode), .iv_i(iv),
      .iv_load_i(iv_load), .v_i(v_sw), .ready_o(ready_s[g]), .data_o(data_s[g]),
      .v_o(v_s[g]), .yumi_i(yumi_sw[g]), .state_o(state_s[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for the result, check latency and (optionally)
  // data against the head of exp_q, then consume it.
  task automatic run_block(input logic [127:0] c, input logic kn, input logic en,
                           input logic md, input logic [127:0] ivv, input logic ivl,
                           input int lat_exp, input logic chk_data, input string tag);
    int n;
    logic [127:0] e;
    @(negedge clk);
    check({tag, "_ready"}, 128'(ready), 128'(1));
    content = c; key = k1; key_new = kn; enc = en; mode = md; iv = ivv; iv_load = ivl;
    v_in = 1'b1;
    @(negedge clk);
    v_in = 1'b0;
    n = 0;
    while (!v_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(lat_exp));
    if (chk_data) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, data, e);
    end
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    check({tag, "_v_drop"}, 128'(v_out), 128'(0));
    check({tag, "_ready_back"}, 128'(ready), 128'(1));
  endtask

  initial begin
    int n;
    int lat [3];
    p2 = p1 ^ c1;
    rst_n = 1'b0;
    content = '0; key = '0; iv = '0;
    key_new = 1'b0; enc = 1'b0; mode = 1'b0; iv_load = 1'b0;
    v_in = 1'b0; yumi = 1'b0; v_sw = 1'b0; yumi_sw = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_v", 128'(v_out), 128'(0));
    check("rst_data", data, '0);
    check("rst_state", 128'(state), 128'(0));
    check("rst_sweep_data", data_s[2], '0);
    rst_n = 1'b1;

    // ECB with expansion, cached decode, forced re-expansion.
    exp_q.push_back(c1);
    run_block(p1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 65, 1'b1, "ecb_enc_expand");
    exp_q.push_back(p1);
    run_block(c1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 33, 1'b1, "ecb_dec_cached");
    exp_q.push_back(c1);
    run_block(p1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 65, 1'b1, "ecb_enc_rekey");

    // Rounds-per-cycle sweep (R = 2, 4, 8) on the standard vector.
    @(negedge clk);
    content = p1; key = k1; key_new = 1'b1; enc = 1'b1; mode = 1'b0; iv_load = 1'b0;
    v_sw = 1'b1;
    @(negedge clk);
    v_sw = 1'b0;
    lat = '{0, 0, 0};
    n = 0;
    while (v_s != 3'b111 && n < 200) begin
      @(negedge clk);
      n++;
      for (int g = 0; g < 3; g++) if (v_s[g] && lat[g] == 0) lat[g] = n;
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("sweep_r%0d_latency", 2 << g), 128'(lat[g]), 128'(64 / (2 << g) + 1));
      check($sformatf("sweep_r%0d_data", 2 << g), data_s[g], c1);
    end
    yumi_sw = 3'b111;
    @(negedge clk);
    yumi_sw = 3'b000;
    check("sweep_v_drop", 128'(v_s), 128'(0));

    // CBC encode two blocks from iv = 0, then decode them back.
    exp_q.push_back(c1);
    run_block(p1, 1'b0, 1'b1, 1'b1, '0, 1'b1, 33, 1'b1, "cbc_enc_b1");
    exp_q.push_back(c1);                         // E(p2 ^ c1) = E(p1)
    run_block(p2, 1'b0, 1'b1, 1'b1, '0, 1'b0, 33, 1'b1, "cbc_enc_b2");
    exp_q.push_back(p1);
    run_block(c1, 1'b0, 1'b0, 1'b1, '0, 1'b1, 33, 1'b1, "cbc_dec_b1");
    exp_q.push_back(p2);
    run_block(c1, 1'b0, 1'b0, 1'b1, '0, 1'b0, 33, 1'b1, "cbc_dec_b2");

    // An ECB block in between must not disturb the chain.
    exp_q.push_back(c1);
    run_block(p1, 1'b0, 1'b1, 1'b1, '0, 1'b1, 33, 1'b1, "cbc_seed");
    run_block(p1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 33, 1'b0, "ecb_between");
    exp_q.push_back(c1);
    run_block(p2, 1'b0, 1'b1, 1'b1, '0, 1'b0, 33, 1'b1, "cbc_after_ecb");

    // Non-zero IV load.
    exp_q.push_back(c1);
    run_block(p2, 1'b0, 1'b1, 1'b1, c1, 1'b1, 33, 1'b1, "cbc_iv_load");

    // Backpressure: hold the result for 10 cycles and poke v_i once.
    @(negedge clk);
    content = p1; key_new = 1'b0; enc = 1'b1; mode = 1'b0; iv_load = 1'b0;
    v_in = 1'b1;
    @(negedge clk);
    v_in = 1'b0;
    n = 0;
    while (!v_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", 128'(n), 128'(33));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        content = c1;
        v_in = 1'b1;
      end else begin
        v_in = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp_hold_data_%0d", i), data, c1);
      check($sformatf("bp_hold_v_%0d", i), 128'(v_out), 128'(1));
      check($sformatf("bp_hold_ready_%0d", i), 128'(ready), 128'(0));
    end
    v_in = 1'b0;
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    check("bp_release_v", 128'(v_out), 128'(0));
    repeat (5) @(negedge clk);
    check("bp_no_ghost_v", 128'(v_out), 128'(0));
    check("bp_idle_state", 128'(state), 128'(0));

    // Reset in the middle of CRYPT, then the next block must re-expand.
    @(negedge clk);
    content = p1; key_new = 1'b0; enc = 1'b1; mode = 1'b0;
    v_in = 1'b1;
    @(negedge clk);
    v_in = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy_ready", 128'(ready), 128'(0));
    check("midrun_state", 128'(state), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", 128'(ready), 128'(1));
    check("midrun_rst_v", 128'(v_out), 128'(0));
    check("midrun_rst_state", 128'(state), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(c1);
    run_block(p1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 65, 1'b1, "after_reset_reexpand");

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
